// File: rtl/cor_pkg.sv
// Shared defaults for the OR/rise-counter block.
package cor_pkg;
  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/cor_sat_cnt.sv
// Saturating up-counter: q advances by one per clock where inc is high and holds at all-ones.
// Latency: one cycle from inc to q. No backpressure; inc is sampled every cycle.
module cor_sat_cnt #(
  parameter int CNT_W = cor_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic at_max;

  assign at_max = &q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cor.sv
// Bitwise OR of x and y with a registered copy, a sticky "seen" flag and a rising-event counter.
// Latency: a is combinational; a_q, seen and rise_cnt follow one clock later. No backpressure.
module cor
  import cor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] a_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             seen
);

  logic rise;

  assign a = x | y;

  // One event per edge no matter how many bits rise together.
  assign rise = |(a & ~a_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      seen <= 1'b0;
    end else begin
      a_q <= a;
      if (|a) begin
        seen <= 1'b1;
      end
    end
  end

  cor_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(rise),
    .q  (rise_cnt)
  );

endmodule

// File: tb/tb_cor.sv
// Directed bench for cor: unclocked OR, reset, multi-bit rise, saturation, mid-cycle reset and glitches.
module tb_cor;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with clock and reset never driven.
  logic clk_nc;
  logic rst_nc;
  logic xn, yn, an, an_q, seen_n;
  logic [7:0] cnt_n;

  logic x1, y1, a1, a1_q, seen1;
  logic [7:0] cnt1;

  logic [3:0] x4, y4, a4, a4_q;
  logic [7:0] cnt4;
  logic       seen4;

  logic       x2, y2, a2, a2_q, seen2;
  logic [1:0] cnt2;

  logic [1:0] exp_cnt2 [10];

  cor u_nc (.clk(clk_nc), .rst(rst_nc), .x(xn), .y(yn), .a(an), .a_q(an_q),
            .rise_cnt(cnt_n), .seen(seen_n));

  cor u1 (.clk(clk), .rst(rst), .x(x1), .y(y1), .a(a1), .a_q(a1_q),
          .rise_cnt(cnt1), .seen(seen1));

  cor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .x(x4), .y(y4), .a(a4), .a_q(a4_q),
                       .rise_cnt(cnt4), .seen(seen4));

  cor #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .x(x2), .y(y2), .a(a2), .a_q(a2_q),
                       .rise_cnt(cnt2), .seen(seen2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    x1 = 0; y1 = 0; x4 = 0; y4 = 0; x2 = 0; y2 = 0;

    // Unclocked OR truth table, 5 ns per step.
    xn = 0; yn = 0; #2 chk("nc_00", 32'(an), 32'd0); #3;
    xn = 0; yn = 1; #2 chk("nc_01", 32'(an), 32'd1); #3;
    xn = 1; yn = 0; #2 chk("nc_10", 32'(an), 32'd1); #3;
    xn = 1; yn = 1; #2 chk("nc_11", 32'(an), 32'd1); #3;
    $display("[TB] unclocked a=%0d", an);

    // Reset state.
    chk("rst_a_q", 32'(a1_q), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_seen", 32'(seen1), 32'd0);

    @(negedge clk);
    rst = 0;
    repeat (3) after_edge();
    chk("idle_a_q", 32'(a1_q), 32'd0);
    chk("idle_cnt", 32'(cnt1), 32'd0);
    chk("idle_seen", 32'(seen1), 32'd0);

    // First rise on the 1-bit instance.
    @(negedge clk);
    y1 = 1;
    #1;
    chk("y1_a_now", 32'(a1), 32'd1);
    chk("y1_a_q_before", 32'(a1_q), 32'd0);
    after_edge();
    chk("y1_a_q", 32'(a1_q), 32'd1);
    chk("y1_cnt", 32'(cnt1), 32'd1);
    chk("y1_seen", 32'(seen1), 32'd1);

    // Multi-bit rise counts once.
    @(negedge clk);
    x4 = 4'b0101; y4 = 4'b0010;
    #1;
    chk("w4_a", 32'(a4), 32'h7);
    after_edge();
    chk("w4_a_q", 32'(a4_q), 32'h7);
    chk("w4_cnt", 32'(cnt4), 32'd1);
    after_edge();
    chk("w4_cnt_hold", 32'(cnt4), 32'd1);

    // Saturation with CNT_W=2: y2 high on odd edges.
    exp_cnt2 = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      y2 = (k % 2 == 0);
      after_edge();
      chk($sformatf("sat_edge%0d", k + 1), 32'(cnt2), 32'(exp_cnt2[k]));
    end

    // Drop y1, then glitch it entirely between two edges.
    @(negedge clk);
    y1 = 0;
    after_edge();
    chk("drop_a_q", 32'(a1_q), 32'd0);
    chk("drop_cnt", 32'(cnt1), 32'd1);
    @(negedge clk);
    y1 = 1;
    #1 chk("glitch_a_hi", 32'(a1), 32'd1);
    y1 = 0;
    #1 chk("glitch_a_lo", 32'(a1), 32'd0);
    after_edge();
    chk("glitch_cnt", 32'(cnt1), 32'd1);
    chk("glitch_a_q", 32'(a1_q), 32'd0);
    chk("glitch_seen", 32'(seen1), 32'd1);

    // Reset pulsed between edges while a is high.
    @(negedge clk);
    y1 = 1;
    rst = 1;
    #1;
    chk("mid_rst_a", 32'(a1), 32'd1);
    chk("mid_rst_a_q", 32'(a1_q), 32'd0);
    chk("mid_rst_cnt", 32'(cnt1), 32'd0);
    chk("mid_rst_seen", 32'(seen1), 32'd0);
    #1;
    rst = 0;
    after_edge();
    chk("post_rst_cnt", 32'(cnt1), 32'd1);
    chk("post_rst_a_q", 32'(a1_q), 32'd1);
    chk("post_rst_seen", 32'(seen1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
